// File: rtl/rv32i_seq_ctrl.sv
// rtl/rv32i_seq_ctrl.sv - multi-cycle RV32I sequencer: owns pc, steps F/D/E/M/W, gates memory and regfile enables
module rv32i_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [31:0] imm,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK
  } state_t;

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait;
  logic        r_halt;
  logic        r_timeout;
  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic        w_waiting;
  logic        w_expired;
  logic        w_taken;
  logic [31:0] w_pc_target;
  logic [31:0] w_pc_new;

  // r_wait counts earlier not-ready cycles, so expiry fires on the MAX_WAIT-th one
  assign w_waiting   = ((r_state == S_FETCH) && !imem_ready) ||
                       ((r_state == S_MEMORY) && !dmem_ready);
  assign w_expired   = w_waiting && ((r_wait + 8'd1) == LP_MAX_WAIT);
  assign w_taken     = jump || (branch && zero);
  assign w_pc_target = w_taken ? (r_pc + imm) : (r_pc + 32'd4);
  assign w_pc_new    = w_pc_target & ~32'd3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start && !r_timeout) w_next = S_FETCH;
      S_FETCH:     if (imem_ready) w_next = S_DECODE;
                   else if (w_expired) w_next = S_IDLE;
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE:   w_next = (mem_read || mem_write) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    if (dmem_ready) w_next = S_WRITEBACK;
                   else if (w_expired) w_next = S_IDLE;
      S_WRITEBACK: w_next = (r_halt || halt) ? S_IDLE : S_FETCH;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ready;
      end
      // a simultaneous read and write request is treated as a store
      S_MEMORY: begin
        dmem_re = mem_read && !mem_write;
        dmem_we = mem_write;
      end
      S_WRITEBACK: reg_we = reg_write;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait    <= 8'd0;
      r_halt    <= 1'b0;
      r_timeout <= 1'b0;
      r_pc      <= RESET_PC;
      r_retired <= 32'd0;
    end else begin
      r_wait <= (w_waiting && !w_expired) ? (r_wait + 8'd1) : 8'd0;
      if (w_expired) begin
        r_timeout <= 1'b1;
      end
      if ((r_state != S_IDLE) && (w_next == S_IDLE)) begin
        r_halt <= 1'b0;
      end else if ((r_state != S_IDLE) && halt) begin
        r_halt <= 1'b1;
      end
      if (r_state == S_WRITEBACK) begin
        r_pc      <= w_pc_new;
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign pc          = r_pc;
  assign retired     = r_retired;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// tb/tb_rv32i_seq_ctrl.sv - self-checking bench for rv32i_seq_ctrl
module tb_rv32i_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MW     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, halt = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        branch = 1'b0, jump = 1'b0, zero = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
  logic [31:0] imm = 32'd0;
  logic [31:0] pc, retired;
  logic        imem_req, ir_load, dmem_re, dmem_we, reg_we, busy, timeout_err;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ret;

  always #5 clk = ~clk;

  rv32i_seq_ctrl #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .branch(branch), .jump(jump), .zero(zero),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .imm(imm), .pc(pc), .imem_req(imem_req), .ir_load(ir_load),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .reg_we(reg_we), .busy(busy),
    .timeout_err(timeout_err), .retired(retired)
  );

  typedef struct {
    int          fw;
    int          dw;
    logic        br, jp, zr, mr, mw, rw;
    logic [31:0] imm;
    int          hlt_at;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input int fw, input int dw, input logic br, input logic jp,
                              input logic zr, input logic mr, input logic mw, input logic rw,
                              input logic [31:0] im, input int hlt_at, input logic [31:0] exp_pc);
    vec_t v;
    v.fw = fw; v.dw = dw; v.br = br; v.jp = jp; v.zr = zr;
    v.mr = mr; v.mw = mw; v.rw = rw; v.imm = im; v.hlt_at = hlt_at; v.exp_pc = exp_pc;
    return v;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] p, input vec_t v);
    logic [31:0] t;
    if (v.jp || (v.br && v.zr)) t = p + v.imm;
    else t = p + 32'd4;
    return {t[31:2], 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    #1;
    chk("idle_before_start", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    chk("start_enters_fetch", {30'd0, busy, imem_req}, 32'd3);
  endtask

  // Drives one instruction from its first FETCH cycle; phase string is the expected schedule
  task automatic run_instr(input vec_t v);
    string      ph;
    byte        p;
    logic       last;
    logic [6:0] exp7;
    ph = "";
    for (int i = 0; i <= v.fw; i++) ph = {ph, "F"};
    ph = {ph, "DE"};
    if (v.mr || v.mw) for (int i = 0; i <= v.dw; i++) ph = {ph, "M"};
    ph = {ph, "W"};
    branch = v.br; jump = v.jp; zero = v.zr;
    mem_read = v.mr; mem_write = v.mw; reg_write = v.rw; imm = v.imm;
    for (int c = 0; c < ph.len(); c++) begin
      p    = ph[c];
      last = (c == ph.len() - 1) || (ph[c+1] != p);
      imem_ready = (p == "F") && last;
      dmem_ready = (p == "M") && last;
      halt       = (c == v.hlt_at);
      #1;
      exp7 = {1'b0, p == "F", (p == "F") && last, (p == "M") && v.mr && !v.mw,
              (p == "M") && v.mw, (p == "W") && v.rw, 1'b1};
      chk($sformatf("enables[%0d] %c", c, p),
          {25'd0, timeout_err, imem_req, ir_load, dmem_re, dmem_we, reg_we, busy}, {25'd0, exp7});
      chk($sformatf("pc_stable[%0d]", c), pc, m_pc);
      tick();
    end
    halt = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    m_pc = v.exp_pc;
    m_ret++;
    chk("pc_after_wb", pc, v.exp_pc);
    chk("retired", retired, m_ret);
    chk("busy_after_wb", {31'd0, busy}, (v.hlt_at >= 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'd0,         -1, 32'd4);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'd0,         -1, 32'd8);
    vecs[2]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, -1, 32'd12);
    vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, -1, 32'd8);
    vecs[4]  = mk(0, 0, 1, 0, 1, 0, 0, 1, 32'hFFFF_FFF8, -1, 32'd0);
    vecs[5]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 32'd6,         -1, 32'd4);
    vecs[6]  = mk(0, 3, 0, 0, 0, 1, 0, 1, 32'd0,         -1, 32'd8);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 32'd0,         -1, 32'd12);
    vecs[8]  = mk(2, 0, 0, 0, 0, 0, 0, 1, 32'd0,         -1, 32'd16);
    vecs[9]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 32'd100,       -1, 32'd116);
    vecs[10] = mk(0, 0, 1, 0, 1, 0, 0, 0, 32'd3,         -1, 32'd116);
    vecs[11] = mk(0, 0, 0, 0, 1, 0, 0, 1, 32'd0,          1, 32'd120);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 1, 32'd0,          4, 32'd124);
    vecs[13] = mk(0, 1, 0, 0, 0, 0, 1, 1, 32'd0,         -1, 32'd128);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, RST_PC);
    chk("reset_retired", retired, 32'd0);
    chk("reset_outputs", {25'd0, timeout_err, imem_req, ir_load, dmem_re, dmem_we, reg_we, busy}, 32'd0);
    #2 rst = 1'b1;
    tick();
    halt = 1'b1;
    tick();
    tick();
    halt = 1'b0;
    chk("halt_in_idle_ignored", {31'd0, busy}, 32'd0);

    m_pc = RST_PC;
    m_ret = 32'd0;
    do_start();
    for (int i = 0; i < 14; i++) begin
      run_instr(vecs[i]);
      if (vecs[i].hlt_at >= 0) do_start();
    end

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      int   len;
      v.fw = $urandom_range(0, 4);
      v.dw = $urandom_range(0, 4);
      v.br = 1'($urandom); v.jp = 1'($urandom_range(0, 3) == 0); v.zr = 1'($urandom);
      v.mr = 1'($urandom); v.mw = 1'($urandom_range(0, 2) == 0); v.rw = 1'($urandom);
      v.imm = $urandom;
      len = v.fw + 4 + ((v.mr || v.mw) ? v.dw + 1 : 0);
      v.hlt_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      v.exp_pc = next_pc(m_pc, v);
      run_instr(v);
      if (v.hlt_at >= 0) do_start();
    end

    branch = 1'b0; jump = 1'b0; zero = 1'b0; mem_write = 1'b0;
    mem_read = 1'b1; reg_write = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    chk("mem_wait_re", {31'd0, dmem_re}, 32'd1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_dmem_re", {31'd0, dmem_re}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_pc", pc, RST_PC);
    chk("async_rst_retired", retired, 32'd0);
    #3 rst = 1'b1;
    tick();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    mem_read = 1'b0; reg_write = 1'b0;
    m_pc = RST_PC;
    m_ret = 32'd0;

    do_start();
    for (int c = 0; c < MW; c++) begin
      chk($sformatf("fetch_wait[%0d]", c), {29'd0, imem_req, busy, timeout_err}, 32'd6);
      tick();
    end
    chk("fetch_timeout_flag", {31'd0, timeout_err}, 32'd1);
    chk("fetch_timeout_busy", {31'd0, busy}, 32'd0);
    chk("fetch_timeout_pc", pc, m_pc);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk("start_ignored_after_timeout", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #3;
    chk("timeout_cleared_by_rst", {31'd0, timeout_err}, 32'd0);
    rst = 1'b1;
    tick();

    do_start();
    mem_write = 1'b1; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    for (int c = 0; c < MW; c++) begin
      chk($sformatf("mem_wait[%0d]", c), {29'd0, dmem_we, busy, timeout_err}, 32'd6);
      tick();
    end
    chk("mem_timeout_flag", {31'd0, timeout_err}, 32'd1);
    chk("mem_timeout_busy", {31'd0, busy}, 32'd0);
    chk("mem_timeout_retired", retired, 32'd0);
    chk("mem_timeout_pc", pc, RST_PC);
    mem_write = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
